// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory streaming controller.
// Holds the FSM state encoding and the stream mode constants.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_LOOP   = 1'b1;

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM: synchronous write, synchronous read with one cycle of latency.
// The storage is named "array" so benches can reach it hierarchically.
module sp_ram #(
  parameter  int DW    = 56,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] array [DEPTH];

  // NOTE: no reset on the storage; resetting a memory array turns it into flops and breaks RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      array[addr] <= wdata;
    end else if (re) begin
      rdata <= array[addr];
    end
  end

endmodule

// File: rtl/mem_stream_ctrl.sv
// Streams a window of the internal RAM out through a valid/ready port, once or in a loop.
// Reads are credit-limited so the 2-entry output FIFO can never overflow.
module mem_stream_ctrl
  import mem_stream_pkg::*;
#(
  parameter  int DW    = 56,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic          mode,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          wr_err
);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d;
  logic [AW:0]   len_q, len_d, remain_q, remain_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;
  logic          wr_err_q;

  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;

  logic          pop, push, issue, flush;
  logic [1:0]    credit;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign done      = done_q;
  assign wr_err    = wr_err_q;

  assign pop    = out_valid && out_ready;
  assign push   = inflight_q;
  assign flush  = stop && busy;
  // Credit counts this cycle's pop so a steady stream keeps one word per cycle.
  assign credit = count_q - {1'b0, pop} + {1'b0, inflight_q};
  assign issue  = (state_q == ST_RUN) && !stop && (remain_q != '0) && (credit < 2'd2);

  // Loads only happen while idle and reads only while busy, so one port suffices.
  assign ram_we   = wr_en && !busy;
  assign ram_addr = busy ? addr_q : wr_addr;

  sp_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (issue),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = length;
          mode_d   = mode;
          addr_d   = base_addr;
          remain_d = length;
          if (length == '0) done_d  = 1'b1;
          else              state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (issue) begin
          if (remain_q == (AW+1)'(1)) begin
            if (mode_q == MODE_LOOP) begin
              addr_d   = base_q;
              remain_d = len_q;
            end else begin
              addr_d   = addr_q + AW'(1);
              remain_d = '0;
              state_d  = ST_DRAIN;
            end
          end else begin
            addr_d   = addr_q + AW'(1);
            remain_d = remain_q - (AW+1)'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (count_q == 2'd0 && !inflight_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      mode_q   <= MODE_SINGLE;
      addr_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      wr_err_q <= wr_en && busy;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else if (flush) begin
      // A stop wins over any transfer this cycle; the in-flight read is dropped.
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= issue;
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
